// File: rtl/obstacle_lane_engine_pkg.sv
// rtl/obstacle_lane_engine_pkg.sv - game state encodings, game_info field positions, lane helpers
package obstacle_lane_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } game_state_t;

  localparam int GI_LANE    = 0;
  localparam int GI_RUN     = 2;
  localparam int GI_RESTART = 3;
  localparam int GI_SPEED   = 4;

  localparam logic [1:0] LANE_NONE = 2'd3;

  function automatic logic [2:0] lane_onehot(input logic [1:0] lane);
    logic [2:0] row;
    row = 3'b000;
    case (lane)
      2'd0:    row = 3'b001;
      2'd1:    row = 3'b010;
      2'd2:    row = 3'b100;
      default: row = 3'b000;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/obstacle_lane_engine_scroll_tick_gen.sv
// rtl/obstacle_lane_engine_scroll_tick_gen.sv - speed-scaled scroll step timer with registered tick pulse
module obstacle_lane_engine_scroll_tick_gen #(
  parameter int SCROLL_BASE_CYC = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int            CW   = $clog2(SCROLL_BASE_CYC + 1);
  localparam logic [CW-1:0] BASE = CW'(SCROLL_BASE_CYC);

  logic [CW-1:0] count;
  logic [CW-1:0] period_m1;

  assign period_m1 = (BASE >> speed) - CW'(1);

  // >= rather than == so a speed increase past the current count still wraps at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      if (count >= period_m1) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + CW'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/obstacle_lane_engine.sv
// rtl/obstacle_lane_engine.sv - 3-lane obstacle field scroller with collision detection and score
module obstacle_lane_engine
  import obstacle_lane_engine_pkg::*;
#(
  parameter int DEPTH           = 16,
  parameter int SCROLL_BASE_CYC = 2_500_000,
  parameter int MIN_GAP         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         game_info,
  input  logic [1:0]         randomized_value,
  output logic               collision_detect,
  output logic               game_over,
  output logic               scroll_tick,
  output logic [3*DEPTH-1:0] obst_map,
  output logic [15:0]        score
);

  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  game_state_t   state;
  game_state_t   next_state;
  logic [1:0]    lane;
  logic          run;
  logic          restart;
  logic [1:0]    speed;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    bottom_ext;
  logic          hit_cond;
  logic          step;
  logic          spawn;
  logic [2:0]    new_row;
  logic          tick_en;
  logic          tick_clr;
  logic          unused_gi;

  assign lane      = game_info[GI_LANE +: 2];
  assign run       = game_info[GI_RUN];
  assign restart   = game_info[GI_RESTART];
  assign speed     = game_info[GI_SPEED +: 2];
  assign unused_gi = ^game_info[7:6];

  // Lane 3 indexes the padding zero, so "no lane" can never collide
  assign bottom_ext = {1'b0, obst_map[3*DEPTH-1 -: 3]};

  obstacle_lane_engine_scroll_tick_gen #(
    .SCROLL_BASE_CYC(SCROLL_BASE_CYC)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (tick_en),
    .clear  (tick_clr),
    .speed  (speed),
    .tick   (scroll_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    hit_cond   = 1'b0;
    step       = 1'b0;
    spawn      = 1'b0;
    new_row    = 3'b000;
    tick_en    = 1'b0;
    tick_clr   = 1'b0;

    if (state == ST_RUN && lane != LANE_NONE) begin
      hit_cond = bottom_ext[lane];
    end

    case (state)
      ST_IDLE: if (run && !restart) next_state = ST_RUN;
      ST_RUN: begin
        if (hit_cond) begin
          next_state = ST_HIT;
        end else if (!run) begin
          next_state = ST_IDLE;
        end
      end
      ST_HIT:  next_state = ST_HIT;
      default: next_state = ST_IDLE;
    endcase

    if (restart) begin
      next_state = ST_IDLE;
    end

    // Counting only while staying in RUN keeps ticks from leaking into IDLE/HIT
    step     = (state == ST_RUN) && scroll_tick && !hit_cond && !restart;
    tick_en  = (state == ST_RUN) && (next_state == ST_RUN);
    tick_clr = restart || (state == ST_HIT);
    spawn    = (randomized_value != LANE_NONE) && (gap_cnt == '0);
    new_row  = spawn ? lane_onehot(randomized_value) : 3'b000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obst_map         <= '0;
      score            <= '0;
      gap_cnt          <= '0;
      collision_detect <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      game_over <= (next_state == ST_HIT);
      if (restart) begin
        obst_map         <= '0;
        score            <= '0;
        gap_cnt          <= '0;
        collision_detect <= 1'b0;
      end else begin
        collision_detect <= hit_cond;
        if (step) begin
          obst_map <= {obst_map[3*DEPTH-4:0], new_row};
          if (spawn) begin
            gap_cnt <= GW'(MIN_GAP);
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end
          if (score != 16'hFFFF) begin
            score <= score + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// tb/tb_obstacle_lane_engine.sv - self-checking bench for obstacle_lane_engine
module tb_obstacle_lane_engine;

  localparam int DEPTH = 4;
  localparam int BASE  = 16;
  localparam int GAP   = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [7:0]         game_info = 8'h00;
  logic [1:0]         randomized_value = 2'd3;
  logic               collision_detect;
  logic               game_over;
  logic               scroll_tick;
  logic [3*DEPTH-1:0] obst_map;
  logic [15:0]        score;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: 0 idle, 1 running, 2 hit
  int         m_state;
  int         m_cnt;
  bit         m_tick;
  bit         m_coll;
  bit         m_over;
  logic [2:0] m_rows[DEPTH];
  int         m_gap;
  int         m_score;

  obstacle_lane_engine #(
    .DEPTH(DEPTH),
    .SCROLL_BASE_CYC(BASE),
    .MIN_GAP(GAP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .game_info        (game_info),
    .randomized_value (randomized_value),
    .collision_detect (collision_detect),
    .game_over        (game_over),
    .scroll_tick      (scroll_tick),
    .obst_map         (obst_map),
    .score            (score)
  );

  always #5 clk = ~clk;

  task automatic set_gi(input logic [1:0] l, input logic r, input logic rs, input logic [1:0] sp);
    game_info = {2'b00, sp, rs, r, l};
  endtask

  function automatic logic [3*DEPTH-1:0] model_map();
    logic [3*DEPTH-1:0] m;
    for (int r = 0; r < DEPTH; r++) m[r*3 +: 3] = m_rows[r];
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_tick = 0; m_coll = 0; m_over = 0; m_gap = 0; m_score = 0;
    for (int r = 0; r < DEPTH; r++) m_rows[r] = 3'b000;
  endtask

  task automatic model_edge();
    int  ln, sp, rv, ns, period;
    bit  rn, rs, hit, stp;
    if (!rst) begin
      model_reset();
      return;
    end
    ln = int'(game_info[1:0]); rn = game_info[2]; rs = game_info[3];
    sp = int'(game_info[5:4]); rv = int'(randomized_value);
    hit = 0;
    if (m_state == 1 && ln < 3) hit = m_rows[DEPTH-1][ln];
    ns = m_state;
    if (m_state == 0 && rn && !rs) ns = 1;
    if (m_state == 1) ns = hit ? 2 : (!rn ? 0 : 1);
    if (rs) ns = 0;
    stp = (m_state == 1) && m_tick && !hit && !rs;
    if (rs || m_state == 2) begin
      m_cnt = 0; m_tick = 0;
    end else if (m_state == 1 && ns == 1) begin
      period = BASE >> sp;
      if (m_cnt >= period - 1) begin m_cnt = 0; m_tick = 1; end
      else begin m_cnt = m_cnt + 1; m_tick = 0; end
    end else begin
      m_tick = 0;
    end
    if (rs) begin
      for (int r = 0; r < DEPTH; r++) m_rows[r] = 3'b000;
      m_score = 0; m_gap = 0; m_coll = 0;
    end else begin
      m_coll = hit;
      if (stp) begin
        for (int r = DEPTH - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
        if (rv < 3 && m_gap == 0) begin
          m_rows[0] = 3'(1 << rv);
          m_gap = GAP;
        end else begin
          m_rows[0] = 3'b000;
          if (m_gap > 0) m_gap = m_gap - 1;
        end
        if (m_score < 65535) m_score = m_score + 1;
      end
    end
    m_over = (ns == 2);
    m_state = ns;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_gi(2'd0, 1'b0, 1'b0, 2'd0);
    model_reset();
    repeat (3) clk_step();
    n_cmp++; if (obst_map !== '0) begin n_bad++; $display("FAIL reset_map got=%h exp=0", obst_map); end
    n_cmp++; if (score !== 16'd0) begin n_bad++; $display("FAIL reset_score got=%0d exp=0", score); end
    n_cmp++; if (collision_detect !== 1'b0) begin n_bad++; $display("FAIL reset_coll got=%b exp=0", collision_detect); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_over got=%b exp=0", game_over); end
    n_cmp++; if (scroll_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", scroll_tick); end
    rst = 1'b1;
    repeat (20) clk_step();
    n_cmp++; if (score !== 16'd0 || scroll_tick !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset score=%0d tick=%b exp 0/0", score, scroll_tick);
    end
  endtask

  task automatic test_scroll_spawn();
    int ticks, last, i;
    ticks = 0; last = -1; i = 0;
    set_gi(2'd0, 1'b1, 1'b0, 2'd0);
    randomized_value = 2'd1;
    while (ticks < 3 && i < 200) begin
      clk_step();
      i++;
      if (scroll_tick) begin
        if (last >= 0) begin
          n_cmp++; if (i - last != 16) begin n_bad++; $display("FAIL tick_period got=%0d exp=16", i - last); end
        end
        last = i;
        ticks++;
      end
    end
    n_cmp++; if (ticks != 3) begin n_bad++; $display("FAIL tick_timeout got=%0d ticks exp=3", ticks); end
    clk_step();
    n_cmp++; if (obst_map !== 12'h082) begin n_bad++; $display("FAIL spawn_pattern got=%h exp=082", obst_map); end
    n_cmp++; if (score !== 16'd3) begin n_bad++; $display("FAIL scroll_score got=%0d exp=3", score); end
  endtask

  task automatic test_async_reset();
    n_cmp++; if (obst_map === '0) begin n_bad++; $display("FAIL precond_map_nonzero got=%h exp=nonzero", obst_map); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (obst_map !== '0 || score !== 16'd0) begin
      n_bad++; $display("FAIL async_reset map=%h score=%0d exp 0/0", obst_map, score);
    end
    n_cmp++; if (scroll_tick !== 1'b0 || collision_detect !== 1'b0 || game_over !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_pulses tick=%b coll=%b over=%b exp 0", scroll_tick, collision_detect, game_over);
    end
    set_gi(2'd0, 1'b0, 1'b0, 2'd0);
    repeat (2) clk_step();
    rst = 1'b1;
    repeat (20) clk_step();
    n_cmp++; if (scroll_tick !== 1'b0 || score !== 16'd0 || obst_map !== '0) begin
      n_bad++; $display("FAIL post_reset_idle tick=%b score=%0d map=%h exp idle", scroll_tick, score, obst_map);
    end
  endtask

  task automatic test_speed_change();
    int i;
    i = 0;
    set_gi(2'd3, 1'b1, 1'b0, 2'd0);
    randomized_value = 2'd3;
    clk_step();
    while (!(m_state == 1 && m_cnt == 10) && i < 100) begin clk_step(); i++; end
    n_cmp++; if (i >= 100) begin n_bad++; $display("FAIL speed_wait_timeout got=%0d exp<100", i); end
    set_gi(2'd3, 1'b1, 1'b0, 2'd3);
    clk_step();
    n_cmp++; if (scroll_tick !== 1'b1) begin n_bad++; $display("FAIL speed_immediate_tick got=%b exp=1", scroll_tick); end
    for (int k = 0; k < 6; k++) begin
      clk_step();
      n_cmp++; if (scroll_tick !== logic'(k % 2 == 1)) begin
        n_bad++; $display("FAIL speed3_tick k=%0d got=%b exp=%b", k, scroll_tick, (k % 2 == 1));
      end
    end
  endtask

  task automatic test_collision_freeze();
    int i, pulses;
    logic [3*DEPTH-1:0] map_hold;
    logic [15:0] score_hold;
    bit bad;
    set_gi(2'd2, 1'b0, 1'b1, 2'd0);
    clk_step();
    set_gi(2'd2, 1'b1, 1'b0, 2'd3);
    randomized_value = 2'd2;
    i = 0;
    while (!collision_detect && i < 200) begin clk_step(); i++; end
    n_cmp++; if (collision_detect !== 1'b1) begin n_bad++; $display("FAIL coll_timeout got=%b exp=1", collision_detect); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL coll_game_over got=%b exp=1", game_over); end
    n_cmp++; if (score !== 16'd4) begin n_bad++; $display("FAIL coll_score got=%0d exp=4", score); end
    n_cmp++; if (obst_map !== 12'h820) begin n_bad++; $display("FAIL coll_map got=%h exp=820", obst_map); end
    map_hold = obst_map; score_hold = score; pulses = 0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      clk_step();
      if (collision_detect) pulses++;
      if (obst_map !== map_hold || score !== score_hold || game_over !== 1'b1) bad = 1;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL hit_refire got=%0d pulses exp=0", pulses); end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL hit_frozen map=%h score=%0d exp=%h/%0d", obst_map, score, map_hold, score_hold); end
  endtask

  task automatic setup_bottom_lane1();
    int i;
    set_gi(2'd0, 1'b0, 1'b1, 2'd3);
    clk_step();
    set_gi(2'd0, 1'b1, 1'b0, 2'd3);
    randomized_value = 2'd1;
    i = 0;
    while (m_rows[DEPTH-1] != 3'b010 && i < 100) begin clk_step(); i++; end
    n_cmp++; if (obst_map[3*DEPTH-1 -: 3] !== 3'b010) begin
      n_bad++; $display("FAIL bottom_setup got=%b exp=010", obst_map[3*DEPTH-1 -: 3]);
    end
  endtask

  task automatic test_lane_change();
    int pulses;
    setup_bottom_lane1();
    set_gi(2'd1, 1'b1, 1'b0, 2'd3);
    clk_step();
    n_cmp++; if (collision_detect !== 1'b1) begin n_bad++; $display("FAIL lane_change_coll got=%b exp=1", collision_detect); end
    set_gi(2'd3, 1'b0, 1'b1, 2'd3);
    clk_step();
    set_gi(2'd3, 1'b1, 1'b0, 2'd3);
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      randomized_value = 2'($urandom_range(0, 2));
      clk_step();
      if (collision_detect || game_over) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL lane_none_coll got=%0d exp=0", pulses); end
    n_cmp++; if (score === 16'd0) begin n_bad++; $display("FAIL lane_none_scroll got=%0d exp>0", score); end
  endtask

  task automatic test_restart_collision();
    setup_bottom_lane1();
    set_gi(2'd1, 1'b1, 1'b1, 2'd3);
    clk_step();
    n_cmp++; if (collision_detect !== 1'b0 || game_over !== 1'b0) begin
      n_bad++; $display("FAIL restart_beats_coll coll=%b over=%b exp 0/0", collision_detect, game_over);
    end
    n_cmp++; if (obst_map !== '0 || score !== 16'd0) begin
      n_bad++; $display("FAIL restart_clear map=%h score=%0d exp 0/0", obst_map, score);
    end
    set_gi(2'd1, 1'b0, 1'b0, 2'd3);
    repeat (10) clk_step();
    n_cmp++; if (scroll_tick !== 1'b0 || score !== 16'd0 || collision_detect !== 1'b0) begin
      n_bad++; $display("FAIL restart_idle tick=%b score=%0d coll=%b exp idle", scroll_tick, score, collision_detect);
    end
  endtask

  task automatic test_random();
    logic [1:0] sp;
    sp = 2'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) sp = 2'($urandom_range(0, 3));
      set_gi(2'($urandom_range(0, 3)), ($urandom_range(0, 19) != 0), ($urandom_range(0, 59) == 0), sp);
      randomized_value = 2'($urandom_range(0, 3));
      clk_step();
      n_cmp++; if (obst_map !== model_map()) begin n_bad++; $display("FAIL rand_map i=%0d got=%h exp=%h", i, obst_map, model_map()); end
      n_cmp++; if (score !== 16'(m_score)) begin n_bad++; $display("FAIL rand_score i=%0d got=%0d exp=%0d", i, score, m_score); end
      n_cmp++; if (collision_detect !== m_coll) begin n_bad++; $display("FAIL rand_coll i=%0d got=%b exp=%b", i, collision_detect, m_coll); end
      n_cmp++; if (game_over !== m_over) begin n_bad++; $display("FAIL rand_over i=%0d got=%b exp=%b", i, game_over, m_over); end
      n_cmp++; if (scroll_tick !== m_tick) begin n_bad++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, scroll_tick, m_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_scroll_spawn();
    test_async_reset();
    test_speed_change();
    test_collision_freeze();
    test_lane_change();
    test_restart_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
